serial_ripple_subtractor: RTL and testbench

SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

---
 rtl/serial_ripple_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial A - B - Bin subtractor, one bit per clock, LSB first.
// Optional signed overflow flag Ovf is built only when RSUB_OVF_EN is defined.
module serial_ripple_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout
`ifdef RSUB_OVF_EN
    ,
    output logic         Ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_diff;
    logic          r_borrow;
    logic          r_bout;
    logic [CW-1:0] r_cnt;

    logic          w_abit;
    logic          w_bbit;
    logic          w_d;
    logic          w_borrow_next;
    logic          w_last;
    logic          w_accept;
    logic [N-1:0]  w_acc_next;

    assign w_abit        = r_a[r_cnt];
    assign w_bbit        = r_b[r_cnt];
    assign w_d           = w_abit ^ w_bbit ^ r_borrow;
    assign w_borrow_next = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_borrow);
    assign w_last        = (r_cnt == LAST);
    assign w_accept      = (r_state == S_IDLE) && in_valid;

    always_comb begin
        w_acc_next        = r_acc;
        w_acc_next[r_cnt] = w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The working accumulator is kept apart from r_diff so the previous result stays visible until the next one completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_next;
            r_borrow <= w_borrow_next;
            if (w_last) begin
                r_diff <= w_acc_next;
                r_bout <= w_borrow_next;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;

`ifdef RSUB_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= (r_a[N-1] != r_b[N-1]) && (w_d != r_a[N-1]);
        end
    end

    assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - randomized and directed self-checking bench for serial_ripple_subtractor.
// Outputs are sampled at the falling edge, i.e. the value the next rising edge will see.
module tb_serial_ripple_subtractor;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Diff;
    logic         Bout;
`ifdef RSUB_OVF_EN
    logic         Ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_ripple_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout)
`ifdef RSUB_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int ed, input int eb, input int eo);
        check({tag, "_diff"}, int'(Diff), ed);
        check({tag, "_bout"}, int'(Bout), eb);
`ifdef RSUB_OVF_EN
        check({tag, "_ovf"}, int'(Ovf), eo);
`else
        if (eo < 0) $display("unexpected overflow model value");
`endif
    endtask

    // Called at a falling edge with the block in IDLE.
    task automatic run_op(input int a, input int b, input int bin, input int hold);
        int ed, eb, eo, lat;
        ed = (a - b - bin) & MASK;
        eb = (a < (b + bin)) ? 1 : 0;
        eo = ((((a >> (N-1)) & 1) != ((b >> (N-1)) & 1)) &&
              (((ed >> (N-1)) & 1) != ((a >> (N-1)) & 1))) ? 1 : 0;

        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        in_valid  = 1'b1;
        A         = N'(a);
        B         = N'(b);
        Bin       = bin[0];
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        A        = N'($urandom);
        B        = N'($urandom);
        Bin      = 1'($urandom);

        lat = 1;
        while (!out_valid && lat <= N + 3) begin
            check("run_in_ready", int'(in_ready), 0);
            in_valid = 1'($urandom);
            step();
            lat++;
        end
        check("latency", lat, N + 1);

        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            A         = N'($urandom);
            B         = N'($urandom);
            Bin       = 1'($urandom);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check_result("hold", ed, eb, eo);
            step();
        end

        check("done_out_valid", int'(out_valid), 1);
        check_result("done", ed, eb, eo);
        in_valid  = 1'b1;
        A         = N'($urandom);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("exit_out_valid", int'(out_valid), 0);
        check("exit_in_ready", int'(in_ready), 1);
        check_result("retain", ed, eb, eo);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        @(negedge clk);
        step();
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check_result("reset", 0, 0, 0);
        rst = 1'b0;
        step();

        run_op(9, 3, 0, 0);
        run_op(3, 9, 0, 2);
        run_op(0, 0, 1, 1);
        run_op(8, 1, 0, 0);
        run_op(15, 15, 1, 0);
        run_op(7, 8, 0, 5);
        run_op(8, 0, 1, 0);

        for (int k = 0; k < 30; k++) begin
            run_op(int'($urandom_range(MASK)), int'($urandom_range(MASK)),
                   int'($urandom_range(1)), int'($urandom_range(3)));
        end

        run_op(5, 2, 0, 0);
        in_valid = 1'b1;
        A        = N'(6);
        B        = N'(1);
        Bin      = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check_result("abort", 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_result", int'(out_valid), 0);
            step();
        end

        run_op(12, 5, 1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
